reg_pipe_amisha: RTL

REG_PIPE_AMISHA -- requirements
Module: reg_pipe_amisha

---
 rtl/reg_pipe_amisha.sv | 62 ++++++
 1 files changed

// File: rtl/reg_pipe_amisha.sv
// Parameterised register pipeline with per-stage valid flags, stall, synchronous flush
// and a registered occupancy count. Bubbles load RESET_VAL so stale input data never enters.
module reg_pipe_amisha #(
  parameter int unsigned        WIDTH     = 8,
  parameter int unsigned        DEPTH     = 3,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic                         clk_amisha,
  input  logic                         reset_n_amisha,
  input  logic                         clear_amisha,
  input  logic                         en_amisha,
  input  logic                         in_valid_amisha,
  input  logic [WIDTH-1:0]             d_amisha,
  output logic [WIDTH-1:0]             q_amisha,
  output logic                         out_valid_amisha,
  output logic [$clog2(DEPTH+1)-1:0]   count_amisha
);

  localparam int CntW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [CntW-1:0]             count_q, count_d;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    count_d = count_q;
    if (clear_amisha) begin
      data_d  = {DEPTH{RESET_VAL}};
      valid_d = '0;
      count_d = '0;
    end else if (en_amisha) begin
      for (int i = int'(DEPTH) - 1; i > 0; i--) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
      // Mux on in_valid keeps don't-care input data out of the pipe.
      data_d[0]  = in_valid_amisha ? d_amisha : RESET_VAL;
      valid_d[0] = in_valid_amisha;
      // Count always equals the number of set valid flags, so it cannot wrap.
      count_d    = count_q + CntW'(in_valid_amisha) - CntW'(valid_q[DEPTH-1]);
    end
  end

  always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
    if (!reset_n_amisha) begin
      data_q  <= {DEPTH{RESET_VAL}};
      valid_q <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign q_amisha         = data_q[DEPTH-1];
  assign out_valid_amisha = valid_q[DEPTH-1];
  assign count_amisha     = count_q;

endmodule
